// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if
//   Operation/result handshake bundle between the EX-stage pipeline and the
//   multi-cycle ALU sequencer.
//
//   Signals:
//     in_valid   - pipeline presents an operation
//     in_ready   - sequencer accepts it (in_valid & in_ready)
//     alu_fun    - 4-bit operation code
//     op1, op2   - operands
//     out_valid  - out_result holds a finished result
//     out_ready  - consumer takes the result (out_valid & out_ready)
//     out_result - registered result
//     busy       - iterative engine is running
//
//   Modports:
//     master - the pipeline side that issues operations and consumes results
//     slave  - the sequencer itself
interface alu_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_fun;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             busy;

    modport master (
        output in_valid, alu_fun, op1, op2, out_ready,
        input  in_ready, out_valid, out_result, busy
    );

    modport slave (
        input  in_valid, alu_fun, op1, op2, out_ready,
        output in_ready, out_valid, out_result, busy
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
//   Multi-cycle ALU sequencer for the EX stage. Single-cycle operations are
//   computed combinationally and registered on acceptance. MUL, MULH, DIV and
//   REM run on an iterative shift-add / restoring-divide engine for WIDTH
//   cycles over operand magnitudes, with the sign applied on the last step.
//
//   Ports:
//     clk   - clock, all state on the rising edge
//     rst_n - asynchronous active-low reset
//     flush - synchronous kill of any in-flight or pending operation
//     bus   - alu_seq_ctrl_if.slave operation/result handshake
//
//   WIDTH must match the WIDTH of the connected interface; the iteration count
//   equals WIDTH and the shift amount is always op2[4:0].
module alu_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst_n,
    input logic          flush,
    alu_seq_ctrl_if.slave bus
);
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_MUL  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_MULH = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_DIV  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_OR   = 4'b1010;
    localparam logic [3:0] ALU_REM  = 4'b1011;
    localparam logic [3:0] ALU_AND  = 4'b1100;
    localparam logic [3:0] ALU_PASS = 4'b1101;

    localparam logic [5:0]       LAST_STEP = 6'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_INT   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [5:0]         count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mag_b;
    logic               neg_a;
    logic               neg_b;
    logic [3:0]         fun_q;

    logic               accept;
    logic               is_slow;
    logic               shortcut;
    logic               div_zero;
    logic               div_ovf;
    logic [4:0]         shamt;
    logic [WIDTH-1:0]   abs_op1;
    logic [WIDTH-1:0]   abs_op2;
    logic [WIDTH-1:0]   fast_result;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   calc_result;

    // A result may only be replaced when nothing is held or the held one is
    // being taken this cycle; flush blocks any new accept.
    assign bus.in_ready = !flush && ((state == IDLE) || (state == DONE && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;

    // Decode of the presented operation: single-cycle result, and whether a
    // slow op can skip the engine (divide by zero, MIN_INT / -1 overflow).
    always_comb begin
        shamt    = bus.op2[4:0];
        abs_op1  = bus.op1[WIDTH-1] ? -bus.op1 : bus.op1;
        abs_op2  = bus.op2[WIDTH-1] ? -bus.op2 : bus.op2;
        div_zero = (bus.op2 == '0);
        div_ovf  = (bus.op1 == MIN_INT) && (bus.op2 == '1);
        is_slow  = (bus.alu_fun == ALU_MUL) || (bus.alu_fun == ALU_MULH) ||
                   (bus.alu_fun == ALU_DIV) || (bus.alu_fun == ALU_REM);
        shortcut = ((bus.alu_fun == ALU_DIV) || (bus.alu_fun == ALU_REM)) && (div_zero || div_ovf);

        fast_result = '0;
        case (bus.alu_fun)
            ALU_ADD:  fast_result = bus.op1 + bus.op2;
            ALU_SUB:  fast_result = bus.op1 - bus.op2;
            ALU_SLL:  fast_result = bus.op1 << shamt;
            ALU_SLT:  fast_result = {{(WIDTH-1){1'b0}}, ($signed(bus.op1) < $signed(bus.op2))};
            ALU_XOR:  fast_result = bus.op1 ^ bus.op2;
            ALU_SRL:  fast_result = bus.op1 >> shamt;
            ALU_SRA:  fast_result = $unsigned($signed(bus.op1) >>> shamt);
            ALU_OR:   fast_result = bus.op1 | bus.op2;
            ALU_AND:  fast_result = bus.op1 & bus.op2;
            ALU_PASS: fast_result = bus.op1;
            ALU_DIV:  fast_result = div_zero ? '1 : MIN_INT;
            ALU_REM:  fast_result = div_zero ? bus.op1 : '0;
            default:  fast_result = '0;
        endcase
    end

    // One engine step. The accumulator's low half starts as |op1| and mag_b
    // holds |op2|. Multiply: add mag_b into the high half when the low bit is
    // set, then shift right. Divide: shift the {remainder, dividend} pair left
    // and subtract mag_b if it fits, shifting in the quotient bit. Since
    // remainder < |op2| <= 2^(WIDTH-1), the shifted remainder never overflows.
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_b};
        if (acc[0]) begin
            mul_next = {mul_sum, acc[WIDTH-1:1]};
        end else begin
            mul_next = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
        end

        rem_shift = acc[2*WIDTH-1:WIDTH-1];
        rem_diff  = rem_shift - {1'b0, mag_b};
        if (!rem_diff[WIDTH]) begin
            div_next = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end

        step_next   = ((fun_q == ALU_DIV) || (fun_q == ALU_REM)) ? div_next : mul_next;
        prod_signed = (neg_a ^ neg_b) ? -step_next : step_next;

        calc_result = '0;
        case (fun_q)
            ALU_MUL:  calc_result = prod_signed[WIDTH-1:0];
            ALU_MULH: calc_result = prod_signed[2*WIDTH-1:WIDTH];
            ALU_DIV:  calc_result = (neg_a ^ neg_b) ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
            ALU_REM:  calc_result = neg_a ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
            default:  calc_result = '0;
        endcase
    end

    // Sequencer FSM with registered outputs. Flush wins over everything but
    // reset and leaves out_result untouched. IDLE and DONE share the accept
    // path because a DONE handshake may accept the next op in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            count          <= '0;
            acc            <= '0;
            mag_b          <= '0;
            neg_a          <= 1'b0;
            neg_b          <= 1'b0;
            fun_q          <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.busy       <= 1'b0;
        end else if (flush) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                CALC: begin
                    acc <= step_next;
                    if (count == LAST_STEP) begin
                        state          <= DONE;
                        bus.out_result <= calc_result;
                        bus.out_valid  <= 1'b1;
                        bus.busy       <= 1'b0;
                    end else begin
                        count <= count + 6'd1;
                    end
                end
                default: begin
                    if (accept) begin
                        if (is_slow && !shortcut) begin
                            state         <= CALC;
                            count         <= '0;
                            acc           <= {{WIDTH{1'b0}}, abs_op1};
                            mag_b         <= abs_op2;
                            neg_a         <= bus.op1[WIDTH-1];
                            neg_b         <= bus.op2[WIDTH-1];
                            fun_q         <= bus.alu_fun;
                            bus.out_valid <= 1'b0;
                            bus.busy      <= 1'b1;
                        end else begin
                            state          <= DONE;
                            bus.out_result <= fast_result;
                            bus.out_valid  <= 1'b1;
                        end
                    end else if (state == DONE && bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
